lfsr_run_ctrl: RTL and testbench

Command-driven sequencer for the project's LFSR datapath. It holds the seed and tap configuration, loads the LFSR, and steps it for a commanded number of cycles or until stopped. It captures the final state and step count and flags configuration, protocol and lock-up errors. It sits between the pad/command decode logic in `user_proj_example` and the LFSR core, in the `wb_clk_i` domain.

---
 rtl/lfsr_run_ctrl.sv | 158 +++++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_run_ctrl.sv
// Command sequencer for the LFSR core: holds seed/taps, loads the core and
// steps it for a commanded count or until STOP, then reports state and count.
module lfsr_run_ctrl #(
    parameter int              WIDTH    = 16,
    parameter int              CNT_W    = 16,
    parameter logic [WIDTH-1:0] SEED_RST = 16'h0001,
    parameter logic [WIDTH-1:0] TAPS_RST = 16'hB400,
    localparam int             DATA_W   = (WIDTH > CNT_W) ? WIDTH : CNT_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [WIDTH-1:0]  lfsr_state,
    output logic              lfsr_load,
    output logic              lfsr_en,
    output logic [WIDTH-1:0]  lfsr_seed,
    output logic [WIDTH-1:0]  lfsr_taps,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  result_o,
    output logic [CNT_W-1:0]  steps_o,
    output logic              err_o,
    output logic [1:0]        err_code
);
    localparam logic [1:0] OP_LOAD_SEED = 2'd0;
    localparam logic [1:0] OP_LOAD_TAPS = 2'd1;
    localparam logic [1:0] OP_RUN       = 2'd2;
    localparam logic [1:0] OP_STOP      = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] seed_reg, seed_next;
    logic [WIDTH-1:0] taps_reg, taps_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] steps_reg, steps_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [CNT_W-1:0] steps_out_reg, steps_out_next;
    logic [1:0]       err_code_reg, err_code_next;
    logic             err_reg, err_next;
    logic             load_reg, load_next;
    logic             accept;
    logic [WIDTH-1:0] cmd_word;
    logic [CNT_W-1:0] cmd_count;

    assign cmd_ready = wb_rst_i && (state_reg != S_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_word  = cmd_data[WIDTH-1:0];
    assign cmd_count = cmd_data[CNT_W-1:0];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_reg     <= S_IDLE;
            seed_reg      <= SEED_RST;
            taps_reg      <= TAPS_RST;
            cnt_reg       <= '0;
            steps_reg     <= '0;
            result_reg    <= '0;
            steps_out_reg <= '0;
            err_code_reg  <= 2'd0;
            err_reg       <= 1'b0;
            load_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            seed_reg      <= seed_next;
            taps_reg      <= taps_next;
            cnt_reg       <= cnt_next;
            steps_reg     <= steps_next;
            result_reg    <= result_next;
            steps_out_reg <= steps_out_next;
            err_code_reg  <= err_code_next;
            err_reg       <= err_next;
            load_reg      <= load_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        seed_next      = seed_reg;
        taps_next      = taps_reg;
        cnt_next       = cnt_reg;
        steps_next     = steps_reg;
        result_next    = result_reg;
        steps_out_next = steps_out_reg;
        err_code_next  = err_code_reg;
        err_next       = 1'b0;
        load_next      = 1'b0;
        lfsr_en        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD_SEED: begin
                            if (cmd_word != '0) begin
                                seed_next = cmd_word;
                                load_next = 1'b1;
                            end else begin
                                err_next      = 1'b1;
                                err_code_next = 2'd1;
                            end
                        end
                        OP_LOAD_TAPS: begin
                            if (cmd_word != '0) begin
                                taps_next = cmd_word;
                            end else begin
                                err_next      = 1'b1;
                                err_code_next = 2'd1;
                            end
                        end
                        OP_RUN: begin
                            cnt_next   = cmd_count;
                            steps_next = '0;
                            state_next = (cmd_count == '0) ? S_DONE : S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // An all-zero state can never leave zero, so abort instead of stepping.
                if (lfsr_state == '0) begin
                    err_next      = 1'b1;
                    err_code_next = 2'd3;
                    state_next    = S_DONE;
                end else begin
                    lfsr_en    = 1'b1;
                    cnt_next   = cnt_reg - CNT_W'(1);
                    steps_next = steps_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(1) || (accept && cmd_op == OP_STOP))
                        state_next = S_DONE;
                    if (accept && cmd_op != OP_STOP) begin
                        err_next      = 1'b1;
                        err_code_next = 2'd2;
                    end
                end
            end
            S_DONE: begin
                result_next    = lfsr_state;
                steps_out_next = steps_reg;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign lfsr_load = load_reg;
    assign lfsr_seed = seed_reg;
    assign lfsr_taps = taps_reg;
    assign busy_o    = (state_reg == S_RUN) || (state_reg == S_DONE);
    assign done_o    = (state_reg == S_DONE);
    assign result_o  = result_reg;
    assign steps_o   = steps_out_reg;
    assign err_o     = err_reg;
    assign err_code  = err_code_reg;
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Bench for lfsr_run_ctrl: a Galois LFSR core model feeds lfsr_state; idle
// commands are table-driven, runs are checked cycle by cycle against rules.
module tb_lfsr_run_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [15:0] lfsr_state;
    logic        lfsr_load, lfsr_en, busy_o, done_o, err_o;
    logic [15:0] lfsr_seed, lfsr_taps, result_o, steps_o;
    logic [1:0]  err_code;

    logic [15:0] core_q;
    logic        force_zero;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [15:0] m_seed, m_taps, m_state;
    logic [1:0]  m_code;

    always #5 clk = ~clk;

    lfsr_run_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .lfsr_state(lfsr_state),
        .lfsr_load (lfsr_load),
        .lfsr_en   (lfsr_en),
        .lfsr_seed (lfsr_seed),
        .lfsr_taps (lfsr_taps),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .steps_o   (steps_o),
        .err_o     (err_o),
        .err_code  (err_code)
    );

    function automatic logic [15:0] adv(logic [15:0] s, logic [15:0] t, int k);
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ t) : (s >> 1);
        return s;
    endfunction

    // LFSR core stand-in, driven by the DUT's load/enable/taps
    always @(posedge clk) begin
        if (!rst_n)         core_q <= 16'h0001;
        else if (lfsr_load) core_q <= lfsr_seed;
        else if (lfsr_en)   core_q <= adv(core_q, lfsr_taps, 1);
    end
    assign lfsr_state = force_zero ? 16'h0000 : core_q;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [15:0] seed;
        logic [15:0] taps;
        logic        load;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    // Applies the command rules in IDLE to the model.
    task automatic model_idle(input logic [1:0] op, input logic [15:0] data,
                              output logic ld, output logic er);
        ld = 1'b0;
        er = 1'b0;
        if (op == 2'd0) begin
            if (data != 0) begin m_seed = data; m_state = data; ld = 1'b1; end
            else begin er = 1'b1; m_code = 2'd1; end
        end else if (op == 2'd1) begin
            if (data != 0) m_taps = data;
            else begin er = 1'b1; m_code = 2'd1; end
        end
    endtask

    task automatic idle_cmd(input logic [1:0] op, input logic [15:0] data,
                            input logic [15:0] e_seed, input logic [15:0] e_taps,
                            input logic e_load, input logic e_err, input logic [1:0] e_code);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        #1 chk("idle_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("seed", lfsr_seed, e_seed);
        chk("taps", lfsr_taps, e_taps);
        chk("load_pulse", lfsr_load, e_load);
        chk("err_pulse", err_o, e_err);
        chk("err_code", err_code, e_code);
        @(negedge clk);
        #1;
        chk("load_once", lfsr_load, 0);
        chk("err_once", err_o, 0);
        $display("idle op=%0d data=%04h seed=%04h taps=%04h code=%0d", op, data, lfsr_seed, lfsr_taps, err_code);
    endtask

    // RUN n; optional STOP at run cycle stop_k, illegal command at ill_k,
    // forced zero state at lock_k (0 = none).
    task automatic do_run(input int n, input int stop_k, input int ill_k,
                          input logic [1:0] ill_op, input int lock_k);
        int steps_e, done_c;
        logic lock_eff;
        logic [1:0] code_e;
        steps_e  = n;
        done_c   = n + 1;
        lock_eff = 1'b0;
        if (stop_k > 0 && stop_k <= n) begin steps_e = stop_k; done_c = stop_k + 1; end
        if (lock_k > 0 && lock_k <= steps_e) begin
            steps_e = lock_k - 1; done_c = lock_k + 1; lock_eff = 1'b1;
        end
        code_e = lock_eff ? 2'd3 : ((ill_k > 0) ? 2'd2 : m_code);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 16'(n);
        @(negedge clk);
        for (int c = 1; c <= done_c + 1; c++) begin
            cmd_valid  = (c == stop_k) || (c == ill_k);
            cmd_op     = (c == stop_k) ? 2'd3 : ill_op;
            cmd_data   = 16'($urandom);
            force_zero = (c == lock_k);
            #1;
            chk("run_en", lfsr_en, (c <= steps_e) ? 1 : 0);
            chk("run_done", done_o, (c == done_c) ? 1 : 0);
            chk("run_busy", busy_o, (c <= done_c) ? 1 : 0);
            chk("run_ready", cmd_ready, (c == done_c) ? 0 : 1);
            chk("run_err", err_o, ((lock_eff && c == lock_k + 1) ||
                                   (ill_k > 0 && c == ill_k + 1)) ? 1 : 0);
            @(negedge clk);
        end
        cmd_valid  = 1'b0;
        force_zero = 1'b0;
        m_state = adv(m_state, m_taps, steps_e);
        m_code  = code_e;
        #1;
        chk("steps_o", steps_o, steps_e);
        chk("result_o", result_o, m_state);
        chk("run_code", err_code, m_code);
        chk("taps_kept", lfsr_taps, m_taps);
        $display("run n=%0d stop=%0d ill=%0d lock=%0d steps=%0d result=%04h code=%0d",
                 n, stop_k, ill_k, lock_k, steps_o, result_o, err_code);
    endtask

    vec_t tbl[7];

    initial begin
        logic ld, er;
        int n, sk, ik;
        logic [1:0] op;
        logic [15:0] d;

        tbl[0] = '{2'd0, 16'h00A5, 16'h00A5, 16'hB400, 1'b1, 1'b0, 2'd0};
        tbl[1] = '{2'd0, 16'h0000, 16'h00A5, 16'hB400, 1'b0, 1'b1, 2'd1};
        tbl[2] = '{2'd1, 16'h0000, 16'h00A5, 16'hB400, 1'b0, 1'b1, 2'd1};
        tbl[3] = '{2'd1, 16'hD008, 16'h00A5, 16'hD008, 1'b0, 1'b0, 2'd1};
        tbl[4] = '{2'd3, 16'h1234, 16'h00A5, 16'hD008, 1'b0, 1'b0, 2'd1};
        tbl[5] = '{2'd1, 16'hB400, 16'h00A5, 16'hB400, 1'b0, 1'b0, 2'd1};
        tbl[6] = '{2'd0, 16'h00A5, 16'h00A5, 16'hB400, 1'b1, 1'b0, 2'd1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 16'h0; force_zero = 1'b0;
        m_seed = 16'h0001; m_taps = 16'hB400; m_state = 16'h0001; m_code = 2'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_seed", lfsr_seed, 16'h0001);
        chk("rst_taps", lfsr_taps, 16'hB400);
        chk("rst_result", result_o, 0);
        chk("rst_steps", steps_o, 0);
        chk("rst_code", err_code, 0);
        chk("rst_strobes", {done_o, err_o, lfsr_load, lfsr_en}, 0);
        $display("reset seed=%04h taps=%04h", lfsr_seed, lfsr_taps);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            idle_cmd(tbl[i].op, tbl[i].data, tbl[i].seed, tbl[i].taps,
                     tbl[i].load, tbl[i].err, tbl[i].code);
            model_idle(tbl[i].op, tbl[i].data, ld, er);
        end

        do_run(5, 0, 0, 2'd0, 0);          // plain run from 0x00A5
        do_run(10, 3, 2, 2'd1, 0);         // STOP at 3, LOAD_TAPS dropped at 2
        do_run(8, 0, 0, 2'd0, 2);          // lock-up on second run cycle
        do_run(0, 0, 0, 2'd0, 0);          // zero-length run
        do_run(6, 6, 0, 2'd0, 0);          // STOP in final-step cycle
        do_run(6, 3, 0, 2'd0, 3);          // lock-up and STOP together

        // reset in the 4th cycle of RUN 20
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 16'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1 chk("mid_en", lfsr_en, 1);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_ready_rst", cmd_ready, 0);
        @(negedge clk);
        #1;
        chk("mid_en_drop", lfsr_en, 0);
        chk("mid_done", done_o, 0);
        chk("mid_busy", busy_o, 0);
        chk("mid_seed", lfsr_seed, 16'h0001);
        chk("mid_taps", lfsr_taps, 16'hB400);
        chk("mid_code", err_code, 0);
        chk("mid_steps", steps_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("mid_no_done", done_o, 0);
        end
        $display("midrun reset seed=%04h taps=%04h en=%0d", lfsr_seed, lfsr_taps, lfsr_en);
        m_seed = 16'h0001; m_taps = 16'hB400; m_state = 16'h0001; m_code = 2'd0;

        for (int it = 0; it < 40; it++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd0) begin
                d = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                model_idle(op, d, ld, er);
                idle_cmd(op, d, m_seed, m_taps, ld, er, m_code);
            end else if (op == 2'd1) begin
                d = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) | 16'h8000);
                model_idle(op, d, ld, er);
                idle_cmd(op, d, m_seed, m_taps, ld, er, m_code);
            end else if (op == 2'd3) begin
                idle_cmd(op, 16'($urandom), m_seed, m_taps, 1'b0, 1'b0, m_code);
            end else begin
                n  = $urandom_range(0, 12);
                sk = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
                ik = 0;
                if ((sk == 0 ? n : sk - 1) >= 1 && $urandom_range(0, 1) == 1)
                    ik = $urandom_range(1, (sk == 0) ? n : sk - 1);
                do_run(n, sk, ik, 2'($urandom_range(0, 2)), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
